fetch_stage: RTL and testbench

//  IF stage of the 5-stage MIPS pipeline, feeding the decode stage directly.
//  - Owns the PC and next-PC selection, the instruction-memory read and the IF/ID register.
//  - Detects end-of-program and drains the pipeline, giving the bench a clean DRAINED flag

---
 rtl/fetch_stage_pkg.sv | 17 +
 rtl/fetch_drain_ctrl.sv | 61 ++++++
 rtl/fetch_stage.sv | 91 +++++++++
 tb/tb_fetch_stage.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the IF stage: bubble/halt encodings and drain FSM states.
package fetch_stage_pkg;

    localparam logic [31:0] DEFAULT_NOP_WORD  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } drain_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_drain_ctrl.sv
// End-of-program controller: once a halt marker is accepted, freezes fetch and
// counts the remaining pipeline stages down before flagging the pipeline drained.
module fetch_drain_ctrl
    import fetch_stage_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic halt_accept,
    output logic halted,
    output logic drained,
    output logic freeze
);

    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DRAIN_CYCLES - 1);

    drain_state_t state;
    drain_state_t state_next;
    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state == ST_RUN && halt_accept) begin
                cnt <= CNT_LOAD;
            end else if (state == ST_DRAIN && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        halted     = 1'b0;
        drained    = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (halt_accept) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                halted = 1'b1;
                if (cnt == '0) state_next = ST_DONE;
            end
            ST_DONE: begin
                halted  = 1'b1;
                drained = 1'b1;
            end
            default: state_next = ST_RUN;
        endcase
        freeze = halted;
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC selection, instruction fetch and the IF/ID
// register, with halt-marker detection handing off to the drain controller.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          IMEM_DEPTH   = 512,
    parameter logic [31:0] HALT_WORD    = DEFAULT_HALT_WORD,
    parameter logic [31:0] NOP_WORD     = DEFAULT_NOP_WORD,
    parameter int          DRAIN_CYCLES = 4,
    localparam int         AW           = $clog2(IMEM_DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          stall,
    input  logic          branch_sel,
    input  logic [31:0]   branch_addr,
    input  logic          jump_sel,
    input  logic [31:0]   jump_addr,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_data,
    output logic [31:0]   pc_f,
    output logic [31:0]   pcplus4_d,
    output logic [31:0]   inst_d,
    output logic          valid_d,
    output logic          halted,
    output logic          drained
);

    logic        freeze;
    logic        redirect;
    logic        in_range;
    logic [31:0] fetch_word;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic        halt_accept;

    assign imem_addr = pc_f[AW+1:2];
    assign in_range  = (pc_f >> 2) < 32'(IMEM_DEPTH);
    // Running off the end of instruction memory is treated as end of program.
    assign fetch_word  = in_range ? imem_data : HALT_WORD;
    assign pc_plus4    = pc_f + 32'd4;
    assign redirect    = jump_sel | branch_sel;
    assign halt_accept = !freeze && !stall && !redirect && (fetch_word == HALT_WORD);

    always_comb begin
        pc_next = pc_f;
        if (!freeze && !stall && !halt_accept) begin
            if (jump_sel)        pc_next = word_align(jump_addr);
            else if (branch_sel) pc_next = word_align(branch_addr);
            else                 pc_next = pc_plus4;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_f      <= word_align(RESET_PC);
            pcplus4_d <= 32'd0;
            inst_d    <= NOP_WORD;
            valid_d   <= 1'b0;
        end else begin
            pc_f <= pc_next;
            if (freeze) begin
                inst_d  <= NOP_WORD;
                valid_d <= 1'b0;
            end else if (!stall) begin
                // Redirects squash the wrong-path fetch; a halt marker never reaches ID.
                if (redirect || fetch_word == HALT_WORD) begin
                    inst_d  <= NOP_WORD;
                    valid_d <= 1'b0;
                end else begin
                    inst_d    <= fetch_word;
                    pcplus4_d <= pc_plus4;
                    valid_d   <= 1'b1;
                end
            end
        end
    end

    fetch_drain_ctrl #(
        .DRAIN_CYCLES(DRAIN_CYCLES)
    ) u_drain (
        .clock      (clock),
        .reset      (reset),
        .halt_accept(halt_accept),
        .halted     (halted),
        .drained    (drained),
        .freeze     (freeze)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scoreboard bench for fetch_stage: expected IF/ID and status values are
// queued as each step is driven and compared one cycle later, after the clock edge.
module tb_fetch_stage;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP  = 32'h0000_0000;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
        logic        halted;
        logic        drained;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_sel;
    logic [31:0] branch_addr;
    logic        jump_sel;
    logic [31:0] jump_addr;
    logic [8:0]  imem_addr;
    logic [31:0] imem_data;
    logic [31:0] pc_f;
    logic [31:0] pcplus4_d;
    logic [31:0] inst_d;
    logic        valid_d;
    logic        halted;
    logic        drained;

    logic [31:0] mem [0:511];
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    fetch_stage dut (
        .clock      (clk),
        .reset      (reset),
        .stall      (stall),
        .branch_sel (branch_sel),
        .branch_addr(branch_addr),
        .jump_sel   (jump_sel),
        .jump_addr  (jump_addr),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .pc_f       (pc_f),
        .pcplus4_d  (pcplus4_d),
        .inst_d     (inst_d),
        .valid_d    (valid_d),
        .halted     (halted),
        .drained    (drained)
    );

    function automatic logic [31:0] word_at(input logic [31:0] addr);
        return 32'h2400_0000 + (addr >> 2);
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic rst, input logic st, input logic br, input logic [31:0] ba,
                         input logic js, input logic [31:0] ja);
        reset       = rst;
        stall       = st;
        branch_sel  = br;
        branch_addr = ba;
        jump_sel    = js;
        jump_addr   = ja;
    endtask

    // Queue the expected post-edge state, clock once, then compare everything pending.
    task automatic step(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                        input logic valid, input logic hlt, input logic drn);
        exp_t e;
        e.tag = tag; e.pc = pc; e.inst = inst; e.valid = valid; e.halted = hlt; e.drained = drn;
        sb.push_back(e);
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, ".pc"},      pc_f,           e.pc);
            check({e.tag, ".inst"},    inst_d,         e.inst);
            check({e.tag, ".valid"},   32'(valid_d),   32'(e.valid));
            check({e.tag, ".halted"},  32'(halted),    32'(e.halted));
            check({e.tag, ".drained"}, 32'(drained),   32'(e.drained));
            // A valid ID instruction is always the one fetched at pc_f-4 with pc_f still there.
            if (e.valid) check({e.tag, ".pcplus4"}, pcplus4_d, e.pc);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = word_at(32'(i) << 2);

        // 1: reset and straight-line fetch
        drive(1, 0, 0, 0, 0, 0);
        step("rst", 32'h0, NOP, 0, 0, 0);
        check("rst.pcplus4", pcplus4_d, 32'h0);
        drive(0, 0, 0, 0, 0, 0);
        step("seq0", 32'h4, word_at(32'h0), 1, 0, 0);
        step("seq1", 32'h8, word_at(32'h4), 1, 0, 0);
        step("seq2", 32'hC, word_at(32'h8), 1, 0, 0);

        // 2: two-cycle stall at PC 8
        drive(1, 0, 0, 0, 0, 0);
        step("rst2", 32'h0, NOP, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        step("pre0", 32'h4, word_at(32'h0), 1, 0, 0);
        step("pre1", 32'h8, word_at(32'h4), 1, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        step("stall0", 32'h8, word_at(32'h4), 1, 0, 0);
        step("stall1", 32'h8, word_at(32'h4), 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        step("resume", 32'hC, word_at(32'h8), 1, 0, 0);

        // 3: branch at 0x10, then jump beating branch (with misaligned jump target)
        step("to10", 32'h10, word_at(32'hC), 1, 0, 0);
        drive(0, 0, 1, 32'h40, 0, 0);
        step("branch", 32'h40, NOP, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        step("at40", 32'h44, word_at(32'h40), 1, 0, 0);
        drive(0, 0, 1, 32'h40, 1, 32'h83);
        step("jmp_wins", 32'h80, NOP, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        step("at80", 32'h84, word_at(32'h80), 1, 0, 0);

        // 4: stall beats jump; jump taken once stall drops
        drive(0, 1, 0, 0, 1, 32'h100);
        step("stall_jmp", 32'h84, word_at(32'h80), 1, 0, 0);
        drive(0, 0, 0, 0, 1, 32'h100);
        step("jmp_after", 32'h100, NOP, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        step("at100", 32'h104, word_at(32'h100), 1, 0, 0);

        // 5: halt marker at word 5; stalled and squashed halts are not taken
        mem[5] = HALT;
        drive(1, 0, 0, 0, 0, 0);
        step("rst5", 32'h0, NOP, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        for (int a = 0; a < 20; a += 4) step("run5", 32'(a + 4), word_at(32'(a)), 1, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        step("halt_stall", 32'h14, word_at(32'h10), 1, 0, 0);
        drive(0, 0, 1, 32'h0, 0, 0);
        step("halt_squash", 32'h0, NOP, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        for (int a = 0; a < 20; a += 4) step("rerun5", 32'(a + 4), word_at(32'(a)), 1, 0, 0);
        step("halt_take", 32'h14, NOP, 0, 1, 0);
        drive(0, 1, 1, 32'h40, 1, 32'h200);
        step("drain1", 32'h14, NOP, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0);
        step("drain2", 32'h14, NOP, 0, 1, 0);
        step("drain3", 32'h14, NOP, 0, 1, 0);
        step("drained", 32'h14, NOP, 0, 1, 1);
        step("sticky", 32'h14, NOP, 0, 1, 1);

        // 6: reset in the middle of a drain
        drive(1, 0, 0, 0, 0, 0);
        step("rst6", 32'h0, NOP, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        for (int a = 0; a < 20; a += 4) step("run6", 32'(a + 4), word_at(32'(a)), 1, 0, 0);
        step("halt6", 32'h14, NOP, 0, 1, 0);
        step("drain6", 32'h14, NOP, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 0);
        step("rst_mid", 32'h0, NOP, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        step("restart", 32'h4, word_at(32'h0), 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
